// File: rtl/fixed_prior_arb_pkg.sv
// -----------------------------------------------------------------------------
// fixed_prior_arb_pkg
// Shared constants and helpers for the fixed-priority arbiter.
//   ARB_DEFAULT_N : default number of requesters.
//   ARB_MAX_N     : widest requester vector the normalisation helper handles.
//   norm_prio()   : reduces a priority vector to one-hot (lowest set bit wins,
//                   an all-zero vector maps to bit 0).
// -----------------------------------------------------------------------------
package fixed_prior_arb_pkg;

  localparam int ARB_DEFAULT_N = 4;
  localparam int ARB_MAX_N     = 64;

  // Isolate the lowest set bit with x & -x; an empty vector falls back to bit 0.
  function automatic logic [ARB_MAX_N-1:0] norm_prio(input logic [ARB_MAX_N-1:0] prio_in);
    logic [ARB_MAX_N-1:0] low_bit;
    low_bit = prio_in & (~prio_in + {{(ARB_MAX_N-1){1'b0}}, 1'b1});
    if (prio_in == {ARB_MAX_N{1'b0}}) begin
      norm_prio = {{(ARB_MAX_N-1){1'b0}}, 1'b1};
    end else begin
      norm_prio = low_bit;
    end
  endfunction

endpackage

// File: rtl/fixed_prior_arbiter_give_if.sv
// -----------------------------------------------------------------------------
// fixed_prior_arbiter_give_if
// Request/grant bundle between requesters and the arbiter.
//   req    : request vector, bit i = requester i
//   enable : arbitration enable
//   prio   : one-hot highest-priority position (normalised inside the arbiter)
//   gnt    : registered one-hot grant
//   valid  : registered, high iff gnt is non-zero
// Modports: master drives requests, slave (the arbiter) drives gnt/valid.
// -----------------------------------------------------------------------------
interface fixed_prior_arbiter_give_if
  import fixed_prior_arb_pkg::*;
#(
  parameter int N = ARB_DEFAULT_N
) ();

  logic [N-1:0] req;
  logic         enable;
  logic [N-1:0] prio;
  logic [N-1:0] gnt;
  logic         valid;

  modport master (
    output req,
    output enable,
    output prio,
    input  gnt,
    input  valid
  );

  modport slave (
    input  req,
    input  enable,
    input  prio,
    output gnt,
    output valid
  );

endinterface

// File: rtl/prior_arb_comb.sv
// -----------------------------------------------------------------------------
// prior_arb_comb
// Purely combinational rotating-priority pick.
//   i_req : request vector
//   i_p   : one-hot highest-priority position (must already be normalised)
//   o_g   : one-hot grant, zero when i_req is zero
// The request vector is doubled so the borrow from subtracting p ripples up
// through non-requesting positions and wraps past bit N-1 into the upper copy;
// the first requester at or above p is the one bit the borrow clears.
// -----------------------------------------------------------------------------
module prior_arb_comb #(
  parameter int N = 4
) (
  input  logic [N-1:0] i_req,
  input  logic [N-1:0] i_p,
  output logic [N-1:0] o_g
);

  logic [2*N-1:0] w_dbl;
  logic [2*N-1:0] w_sub;
  logic [2*N-1:0] w_d;

  assign w_dbl = {i_req, i_req};
  assign w_sub = w_dbl - {{N{1'b0}}, i_p};
  assign w_d   = w_dbl & ~w_sub;
  // A hit lands in the lower copy, or in the upper copy after wrap-around.
  assign o_g   = w_d[N-1:0] | w_d[2*N-1:N];

endmodule

// File: rtl/fixed_prior_arbiter_give.sv
// -----------------------------------------------------------------------------
// fixed_prior_arbiter_give
// N-way fixed-priority arbiter with run-time selectable highest priority.
//   clk : system clock, rising edge
//   rst : asynchronous active-high reset (clears gnt/valid immediately)
//   arb : fixed_prior_arbiter_give_if.slave (req, enable, prio in; gnt, valid out)
// Grant and valid are registered: one cycle latency from sampled inputs.
// Optional build macro FIXED_PRIOR_ARB_HOLD_EN: a granted requester keeps its
// grant while it continues requesting and enable stays high.
// -----------------------------------------------------------------------------
module fixed_prior_arbiter_give
  import fixed_prior_arb_pkg::*;
#(
  parameter int N = ARB_DEFAULT_N
) (
  input logic                       clk,
  input logic                       rst,
  fixed_prior_arbiter_give_if.slave arb
);

  logic [ARB_MAX_N-1:0] w_prio_ext;
  logic [N-1:0]         w_p;
  logic [N-1:0]         w_g;
  logic                 w_hold;
  logic [N-1:0]         w_gnt_nxt;
  logic                 w_valid_nxt;
  logic [N-1:0]         r_gnt;
  logic                 r_valid;

  assign w_prio_ext = ARB_MAX_N'(arb.prio);
  assign w_p        = N'(norm_prio(w_prio_ext));

  prior_arb_comb #(
    .N (N)
  ) u_comb (
    .i_req (arb.req),
    .i_p   (w_p),
    .o_g   (w_g)
  );

`ifdef FIXED_PRIOR_ARB_HOLD_EN
  // The current owner is still requesting: keep its grant regardless of prio.
  assign w_hold = |(r_gnt & arb.req);
`else
  assign w_hold = 1'b0;
`endif

  // Next grant: the lock, a fresh pick, or nothing when arbitration is disabled.
  always_comb begin
    w_gnt_nxt = {N{1'b0}};
    if (arb.enable) begin
      if (w_hold) begin
        w_gnt_nxt = r_gnt;
      end else begin
        w_gnt_nxt = w_g;
      end
    end else begin
      w_gnt_nxt = {N{1'b0}};
    end
    w_valid_nxt = |w_gnt_nxt;
  end

  // Output registers, cleared asynchronously by rst.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_gnt   <= {N{1'b0}};
      r_valid <= 1'b0;
    end else begin
      r_gnt   <= w_gnt_nxt;
      r_valid <= w_valid_nxt;
    end
  end

  assign arb.gnt   = r_gnt;
  assign arb.valid = r_valid;

endmodule

// File: tb/tb_fixed_prior_arbiter_give.sv
// -----------------------------------------------------------------------------
// tb_fixed_prior_arbiter_give
// Self-checking bench: directed vectors plus random traffic, every result
// compared with a search-based reference model of the rotating priority.
// -----------------------------------------------------------------------------
module tb_fixed_prior_arbiter_give;

  localparam int N = 4;

  logic clk;
  logic rst;

  fixed_prior_arbiter_give_if #(.N(N)) bus ();

  fixed_prior_arbiter_give #(.N(N)) dut (
    .clk (clk),
    .rst (rst),
    .arb (bus.slave)
  );

  int n_vec;
  int n_err;

  logic [N-1:0] exp_gnt;
  logic         exp_valid;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_vec++;
    if (obs !== expv) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, expv);
    end
  endtask

  // Reference: find the highest-priority position, then walk cyclically upward.
  function automatic logic [N-1:0] ref_pick(input logic [N-1:0] r, input logic [N-1:0] p);
    int k;
    int idx;
    logic [N-1:0] res;
    k = 0;
    for (int i = N - 1; i >= 0; i--) begin
      if (p[i]) k = i;
    end
    res = '0;
    for (int i = N - 1; i >= 0; i--) begin
      idx = (k + i) % N;
      if (r[idx]) begin
        res = '0;
        res[idx] = 1'b1;
      end
    end
    return res;
  endfunction

  task automatic step(input logic [N-1:0] r, input logic e, input logic [N-1:0] p);
    logic [N-1:0] nxt;
    @(negedge clk);
    bus.req    = r;
    bus.enable = e;
    bus.prio   = p;
    if (!e) begin
      nxt = '0;
    end else begin
      nxt = ref_pick(r, p);
`ifdef FIXED_PRIOR_ARB_HOLD_EN
      if ((exp_gnt & r) != '0) nxt = exp_gnt;
`endif
    end
    exp_gnt   = nxt;
    exp_valid = (nxt != '0);
    @(posedge clk);
    #1;
    chk("gnt", 32'(bus.gnt), 32'(exp_gnt));
    chk("valid", 32'(bus.valid), 32'(exp_valid));
  endtask

  initial begin
    logic [N-1:0] one_i;
    logic [N-1:0] one_j;
    n_vec      = 0;
    n_err      = 0;
    exp_gnt    = '0;
    exp_valid  = 1'b0;
    rst        = 1'b1;
    bus.req    = 4'b0000;
    bus.enable = 1'b0;
    bus.prio   = 4'b0001;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    chk("rst_gnt", 32'(bus.gnt), 32'd0);
    chk("rst_valid", 32'(bus.valid), 32'd0);
    @(negedge clk);
    rst = 1'b0;

    // Single requests under every priority position
    for (int j = 0; j < N; j++) begin
      for (int i = 0; i < N; i++) begin
        one_i = 4'b0001 << i;
        one_j = 4'b0001 << j;
        step(one_i, 1'b1, one_j);
        chk("single", 32'(bus.gnt), 32'(one_i));
      end
    end

    // Exhaustive req for every legal prio
    for (int j = 0; j < N; j++) begin
      for (int r = 0; r < 16; r++) begin
        step(4'(r), 1'b1, 4'b0001 << j);
      end
    end

    // Hand-worked examples; a disabled cycle first so no lock carries over
    step(4'b0000, 1'b0, 4'b0001);
    step(4'b1010, 1'b1, 4'b0001);
    chk("ex_0001_1010", 32'(bus.gnt), 32'h2);
    step(4'b0000, 1'b0, 4'b0001);
    step(4'b1011, 1'b1, 4'b0100);
    chk("ex_0100_1011", 32'(bus.gnt), 32'h8);
    step(4'b0000, 1'b0, 4'b0001);
    step(4'b0110, 1'b1, 4'b1000);
    chk("ex_wrap", 32'(bus.gnt), 32'h2);
    step(4'b0000, 1'b1, 4'b0010);
    chk("ex_noreq_gnt", 32'(bus.gnt), 32'h0);
    chk("ex_noreq_valid", 32'(bus.valid), 32'h0);

    // Enable low, and enable falling clears on the next edge
    step(4'b1111, 1'b0, 4'b0001);
    chk("dis_gnt", 32'(bus.gnt), 32'h0);
    step(4'b1111, 1'b1, 4'b0001);
    chk("en_gnt", 32'(bus.gnt), 32'h1);
    step(4'b1111, 1'b0, 4'b0001);
    chk("en_fall_gnt", 32'(bus.gnt), 32'h0);
    chk("en_fall_valid", 32'(bus.valid), 32'h0);

    // Illegal priority vectors
    step(4'b1100, 1'b1, 4'b0000);
    chk("prio_zero", 32'(bus.gnt), 32'h4);
    step(4'b0000, 1'b0, 4'b0001);
    step(4'b1001, 1'b1, 4'b0110);
    chk("prio_multi", 32'(bus.gnt), 32'h8);

    // Asynchronous reset between edges
    step(4'b0000, 1'b0, 4'b0001);
    step(4'b0100, 1'b1, 4'b0001);
    chk("pre_rst", 32'(bus.gnt), 32'h4);
    #2;
    rst = 1'b1;
    #1;
    chk("async_rst_gnt", 32'(bus.gnt), 32'h0);
    chk("async_rst_valid", 32'(bus.valid), 32'h0);
    exp_gnt   = '0;
    exp_valid = 1'b0;
    @(posedge clk);
    #1;
    chk("rst_held", 32'(bus.gnt), 32'h0);
    @(negedge clk);
    rst = 1'b0;
    step(4'b1011, 1'b1, 4'b0100);
    chk("post_rst", 32'(bus.gnt), 32'h8);

`ifdef FIXED_PRIOR_ARB_HOLD_EN
    // Grant lock
    step(4'b0000, 1'b0, 4'b0001);
    step(4'b0100, 1'b1, 4'b0001);
    chk("hold_first", 32'(bus.gnt), 32'h4);
    step(4'b0101, 1'b1, 4'b0001);
    chk("hold_kept", 32'(bus.gnt), 32'h4);
    step(4'b0001, 1'b1, 4'b0001);
    chk("hold_release", 32'(bus.gnt), 32'h1);
`endif

    // Random traffic, including illegal prio values
    for (int t = 0; t < 400; t++) begin
      step(4'($urandom_range(0, 15)), ($urandom_range(0, 3) != 0),
           4'($urandom_range(0, 15)));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/fixed_prior_arbiter_give.md
Name: fixed_prior_arbiter_give

Overview:
- N-way fixed-priority arbiter whose highest-priority position is supplied at run time by a one-hot `prio` vector.
- Priority descends cyclically upward from that position: prio bit k first, then k+1, ..., N-1, 0, ..., k-1.
- Grant is one-hot and registered; `valid` flags a granted cycle.
- Sits in front of a shared resource (bus, memory port) where software or an upper controller selects the favoured requester.

Parameters:
- N, 4, number of requesters (N >= 2).

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- req  input  N  request vector; bit i = requester i.
- enable  input  1  arbitration enable; a grant is issued only in cycles with enable=1.
- prio  input  N  one-hot highest-priority position (this port replaces the Verilog-era name "priority", a SystemVerilog keyword).
- gnt  output  N  registered one-hot grant (all zero when nothing granted).
- valid  output  1  registered; 1 iff gnt is non-zero.

Behaviour:
- Reset: when rst=1, gnt=0 and valid=0 immediately and held until rst deasserts; no other state exists.
- prio normalisation:
  - prio=0 is treated as prio=1 (bit 0 highest).
  - Multiple bits set: the lowest set bit is used.
- Combinational grant, using the normalised one-hot p:
  - Form the 2N-bit vector d = {req,req} & ~({req,req} - {0,p}).
  - g = d[N-1:0] | d[2N-1:N].
  - Result: the first requester at or cyclically above position k.
  - g=0 when req=0.
- Register update at each rising clk edge with rst=0:
  - enable=1: gnt <= g, valid <= |req.
  - enable=0: gnt <= 0, valid <= 0.
- Latency: one cycle from sampled req/enable/prio to gnt/valid. No request holding across cycles; each cycle is arbitrated independently.
- Invariants: gnt is always one-hot or zero; gnt is always a subset of the req sampled in that cycle; valid == |gnt.
- Wrap-around: with p=bit N-1 and req[N-1]=0, the search continues at bit 0.
- Reset mid-operation clears outputs asynchronously; the first post-reset edge arbitrates normally.

Optional Feature:
- Macro: FIXED_PRIOR_ARB_HOLD_EN.
- Defined: the grant is locked.
  - If gnt[i]=1 and, at the next edge, enable=1 and req[i]=1, then gnt keeps bit i regardless of prio or higher-priority requests.
  - The lock releases when req[i]=0 or enable=0; normal arbitration resumes on the same edge.
  - Reset clears the lock.
- Undefined: pure per-cycle arbitration as above, no lock state.

Decomposition:
- Shared package fixed_prior_arb_pkg:
  - default N constant;
  - function normalising prio to a one-hot value (lowest set bit, zero maps to 1).
- One natural sub-module: prior_arb_comb, purely combinational (req, p) -> g, implementing the double-width subtract.
- The top level adds normalisation, the registers and the optional hold lock.

Test Plan (N=4):
- Single requests: for each prio=1<<j and req=1<<i, pulse enable -> gnt=1<<i, valid=1 one cycle later.
- Exhaustive req 0..15 for each prio. Examples:
  - prio=0001, req=1010 -> gnt=0010.
  - prio=0100, req=1011 -> gnt=1000.
  - prio=1000, req=0110 -> gnt=0010 (wrap).
  - req=0000 -> gnt=0000, valid=0.
- enable=0 with req=1111 -> gnt=0000, valid=0; enable 1->0 clears outputs on the next edge.
- Illegal prio:
  - prio=0000, req=1100 -> gnt=0100.
  - prio=0110, req=1001 -> gnt=1000 (bit 1 used as highest priority).
- Assert rst asynchronously between edges while gnt=0100 -> gnt=0, valid=0 immediately; after release, correct arbitration on the next edge.
- With FIXED_PRIOR_ARB_HOLD_EN:
  - prio=0001, req=0100 granted; then req=0101 -> gnt stays 0100.
  - Drop req[2] -> gnt=0001.
